// File: rtl/pool_window_sequencer_pkg.sv
// Shared types and defaults for the 2x2 pooling window sequencer.
package pool_seq_pkg;
    localparam int FMAP_W_DEF = 8;
    localparam int FMAP_H_DEF = 8;
    localparam int CH_DEF     = 6;
    localparam int DW_DEF     = 4;
    localparam int DRAIN_DEF  = 2;

    localparam logic [1:0] TL = 2'd0;
    localparam logic [1:0] TR = 2'd1;
    localparam logic [1:0] BL = 2'd2;
    localparam logic [1:0] BR = 2'd3;

    typedef enum logic [2:0] {
        IDLE, CLEAR, FETCH, WAIT, ISSUE, DRAIN, DONE
    } state_t;

    // Pixel address of element e of window w, windows in raster order.
    function automatic int win_addr(input int w, input logic [1:0] e, input int fmap_w);
        int hw;
        int row;
        int col;
        hw  = fmap_w / 2;
        row = 2 * (w / hw) + ((e == BL || e == BR) ? 1 : 0);
        col = 2 * (w % hw) + ((e == TR || e == BR) ? 1 : 0);
        return row * fmap_w + col;
    endfunction
endpackage

// File: rtl/pool_window_sequencer_if.sv
// RAM read port and pooling-layer window port of the sequencer.
interface pool_window_sequencer_if
    import pool_seq_pkg::*;
#(
    parameter int AW  = 6,
    parameter int CH  = CH_DEF,
    parameter int DW  = DW_DEF,
    parameter int WIW = 4
);
    logic                   mem_rd_en;
    logic [AW-1:0]          mem_rd_addr;
    logic [CH*DW-1:0]       mem_rd_data;
    logic                   pool_clear;
    logic                   pool_valid;
    logic [CH*4*DW-1:0]     pool_data;
    logic [WIW-1:0]         win_idx;

    modport master (
        output mem_rd_en, mem_rd_addr, pool_clear, pool_valid, pool_data, win_idx,
        input  mem_rd_data
    );
    modport slave (
        input  mem_rd_en, mem_rd_addr, pool_clear, pool_valid, pool_data, win_idx,
        output mem_rd_data
    );
endinterface

// File: rtl/pool_window_sequencer_assembler.sv
// Captures the four pixel words of a window and repacks them per channel.
module pool_window_assembler
    import pool_seq_pkg::*;
#(
    parameter int CH = CH_DEF,
    parameter int DW = DW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_en,
    input  logic [1:0]          rd_tag,
    input  logic [CH*DW-1:0]    rd_data,
    input  logic                load,
    output logic [CH*4*DW-1:0]  pool_data
);
    logic                       rd_vld_d;
    logic [1:0]                 tag_d;
    logic [3:0][CH*DW-1:0]      slot, slot_n;
    logic [CH-1:0][3:0][DW-1:0] pack;

    // The BR word lands in the same cycle the window is loaded, so the
    // window is packed from the post-capture slot view.
    always_comb begin
        slot_n = slot;
        if (rd_vld_d) slot_n[tag_d] = rd_data;
    end

    always_comb begin
        pack = '0;
        for (int c = 0; c < CH; c++)
            for (int e = 0; e < 4; e++)
                pack[c][e] = slot_n[e][c*DW +: DW];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_vld_d  <= 1'b0;
            tag_d     <= TL;
            slot      <= '0;
            pool_data <= '0;
        end else begin
            rd_vld_d <= rd_en;
            tag_d    <= rd_tag;
            slot     <= slot_n;
            if (load) pool_data <= pack;
        end
    end
endmodule

// File: rtl/pool_window_sequencer.sv
// Walks the feature map in 2x2 windows and feeds the pooling datapath.
// Optional POOL_SEQ_PERF_EN adds a busy-cycle counter port perf_cycles.
module pool_window_sequencer
    import pool_seq_pkg::*;
#(
    parameter int FMAP_W       = FMAP_W_DEF,
    parameter int FMAP_H       = FMAP_H_DEF,
    parameter int CH           = CH_DEF,
    parameter int DW           = DW_DEF,
    parameter int DRAIN_CYCLES = DRAIN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    input  logic stall,
    output logic busy,
    output logic done,
`ifdef POOL_SEQ_PERF_EN
    output logic [15:0] perf_cycles,
`endif
    pool_window_sequencer_if.master bus
);
    localparam int AW   = $clog2(FMAP_W * FMAP_H);
    localparam int NWIN = (FMAP_W / 2) * (FMAP_H / 2);
    localparam int WIW  = $clog2(NWIN);
    localparam int DCW  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_t         state, state_n;
    logic [1:0]     e, e_n, tag_q, tag_n;
    logic [WIW-1:0] w, w_n, win_n;
    logic [DCW-1:0] dcnt, dcnt_n;
    logic [AW-1:0]  addr_n;
    logic           hold, busy_n, done_n, clear_n, rd_en_n, valid_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            e     <= TL;
            w     <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_n;
            e     <= e_n;
            w     <= w_n;
            dcnt  <= dcnt_n;
        end
    end

    assign hold = stall && (state == CLEAR || state == FETCH || state == ISSUE);

    always_comb begin
        state_n = state;
        e_n     = e;
        w_n     = w;
        dcnt_n  = dcnt;
        if (abort) begin
            state_n = IDLE;
        end else if (!hold) begin
            case (state)
                IDLE:  if (start) state_n = CLEAR;
                CLEAR: begin
                    state_n = FETCH;
                    w_n     = '0;
                    e_n     = TL;
                end
                FETCH: begin
                    if (e == BR) state_n = WAIT;
                    else         e_n = e + 2'd1;
                end
                WAIT:  state_n = ISSUE;
                ISSUE: begin
                    if (w == WIW'(NWIN - 1)) begin
                        state_n = DRAIN;
                        dcnt_n  = '0;
                    end else begin
                        state_n = FETCH;
                        w_n     = w + WIW'(1);
                        e_n     = TL;
                    end
                end
                DRAIN: begin
                    if (dcnt == DCW'(DRAIN_CYCLES - 1)) state_n = DONE;
                    else                                dcnt_n = dcnt + DCW'(1);
                end
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so that each registered
    // strobe lines up with the cycle its state is occupied; a held cycle
    // re-enters the same state without re-firing the strobe.
    always_comb begin
        busy_n  = (state_n != IDLE);
        done_n  = (state_n == DONE);
        clear_n = (state == IDLE) && (state_n == CLEAR);
        rd_en_n = (state_n == FETCH) && !hold;
        valid_n = (state == WAIT) && (state_n == ISSUE);
        addr_n  = rd_en_n ? AW'(win_addr(int'(w_n), e_n, FMAP_W)) : bus.mem_rd_addr;
        tag_n   = rd_en_n ? e_n : tag_q;
        win_n   = valid_n ? w_n : bus.win_idx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy            <= 1'b0;
            done            <= 1'b0;
            bus.pool_clear  <= 1'b0;
            bus.mem_rd_en   <= 1'b0;
            bus.mem_rd_addr <= '0;
            bus.pool_valid  <= 1'b0;
            bus.win_idx     <= '0;
            tag_q           <= TL;
        end else begin
            busy            <= busy_n;
            done            <= done_n;
            bus.pool_clear  <= clear_n;
            bus.mem_rd_en   <= rd_en_n;
            bus.mem_rd_addr <= addr_n;
            bus.pool_valid  <= valid_n;
            bus.win_idx     <= win_n;
            tag_q           <= tag_n;
        end
    end

    pool_window_assembler #(.CH(CH), .DW(DW)) u_asm (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (bus.mem_rd_en),
        .rd_tag    (tag_q),
        .rd_data   (bus.mem_rd_data),
        .load      (valid_n),
        .pool_data (bus.pool_data)
    );

`ifdef POOL_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                              perf_cycles <= '0;
        else if (clear_n)                      perf_cycles <= '0;
        else if (busy && perf_cycles != 16'hFFFF) perf_cycles <= perf_cycles + 16'd1;
    end
`endif
endmodule

// File: doc/pool_window_sequencer.md
# pool_window_sequencer

Controller that drives the 6-channel 2x2 max-pooling datapath from the convolution output feature-map RAM. On `start` it clears pooling storage, then walks the 8x8 map in raster order of 2x2 windows (16 windows). For each window it reads four pixel words from a synchronous RAM, packs them into the pooling layer's window format, and pulses `pool_valid` once. It signals `done` after the pooling pipeline has drained.

## Interface
- FMAP_W, 8, feature-map width in pixels; even.
- FMAP_H, 8, feature-map height in pixels; even.
- CH, 6, channels per pixel word.
- DW, 4, bits per channel element.
- DRAIN_CYCLES, 2, cycles between last `pool_valid` and `done`.
- Derived: AW = $clog2(FMAP_W*FMAP_H) = 6; NWIN = (FMAP_W/2)*(FMAP_H/2) = 16; WIW = $clog2(NWIN) = 4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  begin a pass; sampled only in IDLE.
- abort  in  1  synchronous cancel; return to IDLE, no `done`.
- stall  in  1  freeze sequencing (see Operation).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of pass.
- mem_rd_en  out  1  RAM read strobe.
- mem_rd_addr  out  AW  pixel address = row*FMAP_W + col.
- mem_rd_data  in  CH*DW  pixel word, valid the cycle after `mem_rd_en`; channel k at [DW*k +: DW].
- pool_clear  out  1  one-cycle storage-clear pulse to the pooling layer.
- pool_valid  out  1  one-cycle window strobe.
- pool_data  out  CH*4*DW  window data; channel k at [4*DW*k +: 4*DW]; within a channel: [DW-1:0] TL, [2DW-1:DW] TR, [3DW-1:2DW] BL, [4DW-1:3DW] BR.
- win_idx  out  WIW  index of window on `pool_data`.
- perf_cycles  out  16  present only with POOL_SEQ_PERF_EN.

## Operation
- FSM states: IDLE, CLEAR, FETCH, WAIT, ISSUE, DRAIN, DONE.
- IDLE: on `start`=1 and `abort`=0, go to CLEAR.
- CLEAR: `pool_clear`=1 for one cycle, set window counter w=0, then go to FETCH.
- FETCH: 4 cycles, element e=0..3. Each cycle drives `mem_rd_en`=1 and an address. With base = (2*(w/(FMAP_W/2)))*FMAP_W + 2*(w%(FMAP_W/2)), the addresses are base, base+1, base+FMAP_W, base+FMAP_W+1 (TL, TR, BL, BR). After e=3, go to WAIT.
- Data capture: the block keeps a 1-cycle delayed copy of `mem_rd_en` and the element tag. It captures `mem_rd_data` into the element slot whenever that delayed strobe is set, independent of `stall`.
- WAIT: 1 cycle for the BR data to arrive, then go to ISSUE.
- ISSUE: registers `pool_data` from the captured slots, `win_idx`=w, `pool_valid`=1 for one cycle. If w=NWIN-1, go to DRAIN; otherwise w++ and go to FETCH.
- DRAIN: count DRAIN_CYCLES, then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `stall`=1 holds CLEAR, FETCH and ISSUE in place. While held, the strobe (`pool_clear`, `mem_rd_en`, `pool_valid`) is 0 and the counters do not move. WAIT, DRAIN and DONE ignore `stall`.
- `abort` has priority over `stall` and `start`, and applies in any state. Next cycle: IDLE, all strobes 0, `pool_data` and `win_idx` hold their last values.
- `start` outside IDLE is ignored. The earliest restart is the cycle after `done`.
- `pool_data` and `win_idx` stay stable between ISSUE cycles.

## Timing
- Reset: state IDLE. `busy`, `done`, `mem_rd_en`, `pool_clear`, `pool_valid` = 0. `mem_rd_addr`, `pool_data`, `win_idx`, `perf_cycles` = 0. Capture slots = 0. Reset mid-pass discards the pass, and no `done` is produced.
- All outputs are registered.
- Unstalled pass, with `start` sampled at cycle 0:
  - CLEAR in cycle 1.
  - Window k: FETCH in cycles 2+6k .. 5+6k, WAIT in 6+6k, ISSUE in 7+6k.
  - Last ISSUE in cycle 97; DRAIN in cycles 98..99; `done` in cycle 100.
  - `busy` is high in cycles 1..100.
- Each stalled cycle adds exactly one cycle of latency.

## Configuration
- POOL_SEQ_PERF_EN defined: `perf_cycles` port exists. It clears on entry to CLEAR, increments every cycle `busy`=1, saturates at 16'hFFFF, and holds after `done`/abort.
- POOL_SEQ_PERF_EN undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package pool_seq_pkg holds:
  - the state enum;
  - default FMAP_W/FMAP_H/CH/DW constants;
  - element tag constants TL=0, TR=1, BL=2, BR=3.
- Sub-module pool_window_assembler holds the delayed-strobe capture, the four CH*DW slots, and the repack into the `pool_data` layout. The top level holds the FSM, counters and address generation.

## Test plan
- Full pass, RAM word = {CH{addr[3:0]}} -> `pool_clear` at cycle 1; `pool_data[15:0]`=16'h9810 at cycle 7 (win 0); 16'hBA32 at win 5 (cycle 37); `done` at cycle 100; exactly 16 `pool_valid`.
- Address order -> window 0 reads 0, 1, 8, 9; window 15 reads 54, 55, 62, 63.
- `stall` high 3 cycles during window 2 FETCH, plus 2 cycles during its ISSUE -> no duplicate reads, data unchanged, `done` at cycle 105.
- `abort` at cycle 40 -> IDLE at cycle 41, no `done`. A new `start` at cycle 45 reproduces the full-pass results offset by 45.
- `rst` low at cycle 50 -> all outputs 0 immediately. `start` during `busy` -> ignored; pass completes unchanged.
- With POOL_SEQ_PERF_EN -> `perf_cycles`=100 after the unstalled pass, and 105 after the stalled pass.
